mul_share_arbiter: RTL and testbench

- Shares one pipelined unsigned array multiplier between N_REQ requesters.
- Grants one operand pair per cycle using round-robin arbitration.
- Converts signed requests to sign/magnitude form before issue, and reapplies the sign to the returning product.
- Tags every issued operation with its requester ID; drives the multiplier's clock enable to stall the whole pipe when the result consumer applies backpressure.

---
 rtl/mul_share_arbiter.sv | 135 +++++++++++++
 tb/tb_mul_share_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter.sv
// Round-robin front end that shares one pipelined unsigned multiplier between N_REQ requesters,
// handling signed operands via sign/magnitude conversion and tagging results with requester ID.
module mul_share_arbiter #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned PIPELINE_DEPTH = 4,
  parameter int unsigned N_REQ          = 4,
  localparam int unsigned ID_W          = $clog2(N_REQ),
  localparam int unsigned CNT_W         = $clog2(PIPELINE_DEPTH) + 1
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [N_REQ-1:0]              req_valid_i,
  output logic [N_REQ-1:0]              req_ready_o,
  input  logic [N_REQ-1:0]              req_signed_i,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_multiplicand_i,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_multiplier_i,
  output logic                          mul_clk_en_o,
  output logic                          mul_data_valid_o,
  output logic [DATA_WIDTH-1:0]         mul_multiplicand_o,
  output logic [DATA_WIDTH-1:0]         mul_multiplier_o,
  input  logic [2*DATA_WIDTH-1:0]       mul_product_i,
  input  logic                          mul_data_valid_i,
  output logic                          res_valid_o,
  input  logic                          res_ready_i,
  output logic [2*DATA_WIDTH-1:0]       res_product_o,
  output logic [ID_W-1:0]               res_id_o,
  output logic [CNT_W-1:0]              inflight_o
);

  localparam int unsigned DW  = DATA_WIDTH;
  localparam int unsigned LAT = PIPELINE_DEPTH - 1;

  logic                  stall;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]      grant;
  logic [ID_W-1:0]       gnt_id;
  logic                  gnt_any;
  int unsigned           idx;

  logic [DW-1:0]         op_a, op_b;
  logic                  op_sgn, issue_neg;

  logic [LAT-1:0]            tag_vld_q, tag_neg_q;
  logic [LAT-1:0][ID_W-1:0]  tag_id_q;
  logic [CNT_W-1:0]          inflight_q, inflight_d;
  logic                      res_done;

  // A held result freezes the whole multiplier pipe and blocks new issues.
  assign stall        = res_valid_o & ~res_ready_i;
  assign mul_clk_en_o = ~stall;

  always_comb begin
    grant   = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = 0;
    if (!stall) begin
      for (int unsigned o = 0; o < N_REQ; o++) begin
        idx = (32'(rr_ptr_q) + o) % N_REQ;
        if (!gnt_any && req_valid_i[idx]) begin
          grant[idx] = 1'b1;
          gnt_id     = ID_W'(idx);
          gnt_any    = 1'b1;
        end
      end
    end
  end

  assign req_ready_o = grant;
  assign rr_ptr_d    = gnt_any ? ID_W'((32'(gnt_id) + 1) % N_REQ) : rr_ptr_q;

  always_comb begin
    op_a   = '0;
    op_b   = '0;
    op_sgn = 1'b0;
    if (gnt_any) begin
      op_a   = req_multiplicand_i[32'(gnt_id)*DW +: DW];
      op_b   = req_multiplier_i[32'(gnt_id)*DW +: DW];
      op_sgn = req_signed_i[gnt_id];
    end
  end

  // Negating the most-negative value wraps to 2^(DW-1), which is the exact magnitude.
  assign mul_multiplicand_o = (op_sgn && op_a[DW-1]) ? -op_a : op_a;
  assign mul_multiplier_o   = (op_sgn && op_b[DW-1]) ? -op_b : op_b;
  assign issue_neg          = op_sgn & (op_a[DW-1] ^ op_b[DW-1]);
  assign mul_data_valid_o   = gnt_any;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rr_ptr_q  <= '0;
      tag_vld_q <= '0;
      tag_neg_q <= '0;
      tag_id_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (mul_clk_en_o) begin
        tag_vld_q[0] <= gnt_any;
        tag_neg_q[0] <= issue_neg;
        tag_id_q[0]  <= gnt_id;
        for (int i = 1; i < LAT; i++) begin
          tag_vld_q[i] <= tag_vld_q[i-1];
          tag_neg_q[i] <= tag_neg_q[i-1];
          tag_id_q[i]  <= tag_id_q[i-1];
        end
      end
    end
  end

  assign res_valid_o   = mul_data_valid_i;
  assign res_id_o      = tag_id_q[LAT-1];
  assign res_product_o = tag_neg_q[LAT-1] ? -mul_product_i : mul_product_i;

  assign res_done = res_valid_o & res_ready_i;

  always_comb begin
    inflight_d = inflight_q;
    unique case ({gnt_any, res_done})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  assign inflight_o = inflight_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with a behavioural pipelined multiplier attached.
module tb_mul_share_arbiter;

  localparam int unsigned DW  = 16;
  localparam int unsigned NR  = 4;
  localparam int unsigned PD  = 4;
  localparam int unsigned LAT = PD - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid, req_ready, req_signed;
  logic [NR*DW-1:0]  req_a, req_b;
  logic              mul_clk_en, mul_dv_o, mul_dv_i;
  logic [DW-1:0]     mul_a, mul_b;
  logic [2*DW-1:0]   mul_p;
  logic              res_valid, res_ready;
  logic [2*DW-1:0]   res_product;
  logic [1:0]        res_id;
  logic [2:0]        inflight;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_share_arbiter #(
    .DATA_WIDTH    (DW),
    .PIPELINE_DEPTH(PD),
    .N_REQ         (NR)
  ) dut (
    .clk_i             (clk),
    .rst_n_i           (rst_n),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready),
    .req_signed_i      (req_signed),
    .req_multiplicand_i(req_a),
    .req_multiplier_i  (req_b),
    .mul_clk_en_o      (mul_clk_en),
    .mul_data_valid_o  (mul_dv_o),
    .mul_multiplicand_o(mul_a),
    .mul_multiplier_o  (mul_b),
    .mul_product_i     (mul_p),
    .mul_data_valid_i  (mul_dv_i),
    .res_valid_o       (res_valid),
    .res_ready_i       (res_ready),
    .res_product_o     (res_product),
    .res_id_o          (res_id),
    .inflight_o        (inflight)
  );

  // Multiplier model: LAT stages, frozen when clock enable is low.
  logic [LAT-1:0]   mv;
  logic [2*DW-1:0]  mp [LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv <= '0;
      for (int i = 0; i < LAT; i++) mp[i] <= '0;
    end else if (mul_clk_en) begin
      mv    <= {mv[LAT-2:0], mul_dv_o};
      mp[0] <= (2*DW)'(mul_a) * (2*DW)'(mul_b);
      for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
    end
  end

  assign mul_dv_i = mv[LAT-1];
  assign mul_p    = mp[LAT-1];

  always @(negedge clk) begin
    checks++;
    assert (mul_dv_i === dut.tag_vld_q[LAT-1]) else begin
      errors++;
      $error("FAIL tag_align observed=%0b expected=%0b", dut.tag_vld_q[LAT-1], mul_dv_i);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic sgn, input logic [DW-1:0] a,
                         input logic [DW-1:0] b);
    req_valid[i]         = 1'b1;
    req_signed[i]        = sgn;
    req_a[i*DW +: DW]    = a;
    req_b[i*DW +: DW]    = b;
  endtask

  task automatic clr_req();
    req_valid  = '0;
    req_signed = '0;
  endtask

  task automatic set_all();
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, DW'(i + 1), 16'd100);
  endtask

  task automatic chk_res(input string tag, input logic [1:0] id, input logic [31:0] p);
    chk({tag, "_valid"}, 32'(res_valid), 32'd1);
    chk({tag, "_id"}, 32'(res_id), 32'(id));
    chk({tag, "_prod"}, res_product, p);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_signed = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b1;
    #3;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_clken", 32'(mul_clk_en), 32'd1);
    chk("rst_mdv", 32'(mul_dv_o), 32'd0);
    chk("rst_ma", 32'(mul_a), 32'd0);
    chk("rst_rvalid", 32'(res_valid), 32'd0);
    chk("rst_prod", res_product, 32'd0);
    chk("rst_id", 32'(res_id), 32'd0);
    chk("rst_infl", 32'(inflight), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single unsigned op from requester 0
    set_req(0, 1'b0, 16'd300, 16'd200);
    #1;
    chk("u_ready", 32'(req_ready), 32'b0001);
    chk("u_mdv", 32'(mul_dv_o), 32'd1);
    chk("u_a", 32'(mul_a), 32'd300);
    chk("u_b", 32'(mul_b), 32'd200);
    chk("u_infl0", 32'(inflight), 32'd0);
    tick(); clr_req(); #1;
    chk("u_infl1", 32'(inflight), 32'd1);
    chk("u_novalid", 32'(res_valid), 32'd0);
    tick(); #1;
    chk("u_infl2", 32'(inflight), 32'd1);
    tick(); #1;
    chk_res("u_res", 2'd0, 32'd60000);
    chk("u_infl3", 32'(inflight), 32'd1);
    tick(); #1;
    chk("u_done_valid", 32'(res_valid), 32'd0);
    chk("u_done_infl", 32'(inflight), 32'd0);

    // Signed ops from requester 2 (pointer is 1)
    set_req(2, 1'b1, 16'hFFFB, 16'd7);
    #1;
    chk("s1_ready", 32'(req_ready), 32'b0100);
    chk("s1_a", 32'(mul_a), 32'd5);
    chk("s1_b", 32'(mul_b), 32'd7);
    tick();
    set_req(2, 1'b1, 16'h8000, 16'h8000);
    #1;
    chk("s2_ready", 32'(req_ready), 32'b0100);
    chk("s2_a", 32'(mul_a), 32'h8000);
    chk("s2_b", 32'(mul_b), 32'h8000);
    tick();
    set_req(2, 1'b1, 16'h0000, 16'hFFFF);
    #1;
    chk("s3_a", 32'(mul_a), 32'd0);
    chk("s3_b", 32'(mul_b), 32'd1);
    tick(); clr_req(); #1;
    chk_res("s1_res", 2'd2, 32'hFFFF_FFDD);
    tick(); #1;
    chk_res("s2_res", 2'd2, 32'h4000_0000);
    tick(); #1;
    chk_res("s3_res", 2'd2, 32'd0);
    tick(); #1;
    chk("s_infl", 32'(inflight), 32'd0);

    // Pointer wrap with sparse requests (pointer is 3)
    set_req(1, 1'b0, 16'd3, 16'd4);
    #1;
    chk("w1_ready", 32'(req_ready), 32'b0010);
    tick();
    set_req(3, 1'b0, 16'd10, 16'd11);
    #1;
    chk("w2_ready", 32'(req_ready), 32'b1000);
    tick(); clr_req(); #1;
    tick(); #1;
    chk_res("w1_res", 2'd1, 32'd12);
    tick(); #1;
    chk_res("w2_res", 2'd3, 32'd110);
    tick();

    // Fairness: all requesters valid (pointer is 0)
    set_all();
    for (int c = 0; c < 8; c++) begin
      if (c == 5) clr_req();
      #1;
      if (c < 5) chk("rr_ready", 32'(req_ready), 32'(1 << (c % 4)));
      if (c >= 3) chk_res("rr_res", 2'((c - 3) % 4), 32'(((c - 3) % 4 + 1) * 100));
      tick();
    end

    // Backpressure (pointer is 1)
    set_all();
    #1; chk("bp_g0", 32'(req_ready), 32'b0010);
    tick(); #1; chk("bp_g1", 32'(req_ready), 32'b0100);
    tick(); #1; chk("bp_g2", 32'(req_ready), 32'b1000);
    tick();
    res_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_clken", 32'(mul_clk_en), 32'd0);
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk_res("bp_hold", 2'd1, 32'd200);
      chk("bp_infl", 32'(inflight), 32'd3);
      tick();
    end
    res_ready = 1'b1;
    #1;
    chk("bp_rel_clken", 32'(mul_clk_en), 32'd1);
    chk("bp_rel_ready", 32'(req_ready), 32'b0001);
    chk_res("bp_r1", 2'd1, 32'd200);
    tick(); clr_req(); #1;
    chk_res("bp_r2", 2'd2, 32'd300);
    tick(); #1;
    chk_res("bp_r3", 2'd3, 32'd400);
    tick(); #1;
    chk_res("bp_r0", 2'd0, 32'd100);
    tick(); #1;
    chk("bp_end_valid", 32'(res_valid), 32'd0);
    chk("bp_end_infl", 32'(inflight), 32'd0);

    // Reset with three operations in flight
    set_all();
    tick(); tick(); tick();
    clr_req();
    rst_n = 1'b0;
    #1;
    chk("mr_ready", 32'(req_ready), 32'd0);
    chk("mr_clken", 32'(mul_clk_en), 32'd1);
    chk("mr_mdv", 32'(mul_dv_o), 32'd0);
    chk("mr_rvalid", 32'(res_valid), 32'd0);
    chk("mr_prod", res_product, 32'd0);
    chk("mr_id", 32'(res_id), 32'd0);
    chk("mr_infl", 32'(inflight), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("mr_stale", 32'(res_valid), 32'd0);
      chk("mr_infl_after", 32'(inflight), 32'd0);
      tick();
    end
    set_all();
    #1;
    chk("mr_ptr", 32'(req_ready), 32'b0001);
    tick(); clr_req();
    tick(); tick(); #1;
    chk_res("mr_res", 2'd0, 32'd100);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
